// File: rtl/imm_gen_stage.sv
// Immediate generator for the decode stage: decodes and extends the instruction immediate,
// flags bad shift amounts, and buffers results in a two-entry head/skid pipeline stage.
module imm_gen_stage #(
    parameter int XLEN    = 32,
    parameter bit HAS_CSR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam bit IS64 = (XLEN == 64);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    localparam logic [2:0] FMT_SH   = 3'd7;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_t;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_is_shift;
    logic [31:0]     w_imm32;
    logic            w_sext;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;

    assign w_opcode   = in_inst[6:0];
    assign w_funct3   = in_inst[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // w_imm32 is already sign-filled to 32 bits; w_sext extends that sign above bit 31.
    always_comb begin
        w_fmt     = FMT_NONE;
        w_imm32   = '0;
        w_sext    = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_fmt   = FMT_U;
                w_imm32 = {in_inst[31:12], 12'b0};
                w_sext  = 1'b1;
            end
            OPC_JAL: begin
                w_fmt   = FMT_J;
                w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
                w_sext  = 1'b1;
            end
            OPC_JALR, OPC_LOAD: begin
                w_fmt   = FMT_I;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                w_sext  = 1'b1;
            end
            OPC_STORE: begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                w_sext  = 1'b1;
            end
            OPC_BRANCH: begin
                w_fmt   = FMT_B;
                w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
                w_sext  = 1'b1;
            end
            OPC_OP_IMM: begin
                if (w_is_shift) begin
                    w_fmt = FMT_SH;
                    if (IS64) begin
                        w_imm32 = {26'b0, in_inst[25:20]};
                    end else begin
                        w_imm32   = {27'b0, in_inst[24:20]};
                        w_illegal = in_inst[25];
                    end
                end else begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    w_sext  = 1'b1;
                end
            end
            OPC_OP_IMM32: begin
                if (IS64) begin
                    if (w_is_shift) begin
                        w_fmt     = FMT_SH;
                        w_imm32   = {27'b0, in_inst[24:20]};
                        w_illegal = in_inst[25];
                    end else begin
                        w_fmt   = FMT_I;
                        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                        w_sext  = 1'b1;
                    end
                end
            end
            OPC_SYSTEM: begin
                if (HAS_CSR && w_funct3[2]) begin
                    w_fmt   = FMT_Z;
                    w_imm32 = {27'b0, in_inst[19:15]};
                end
            end
            default: ;
        endcase
    end

    assign w_imm[31:0] = w_imm32;
    for (genvar gi = 32; gi < XLEN; gi++) begin : g_ext
        assign w_imm[gi] = w_sext & w_imm32[31];
    end

    count_t          r_count;
    count_t          w_count_next;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_load_head_in;
    logic            w_load_head_skid;
    logic            w_load_skid;

    logic [XLEN-1:0] r_head_imm;
    logic [2:0]      r_head_fmt;
    logic            r_head_ill;
    logic [XLEN-1:0] r_head_pc;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_fmt;
    logic            r_skid_ill;
    logic [XLEN-1:0] r_skid_pc;

    assign in_ready   = (r_count != FULL);
    assign out_valid  = (r_count != EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Flush wins over any handshake; data registers are left stale on purpose.
    always_comb begin
        w_count_next     = r_count;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_count_next = EMPTY;
        end else begin
            case (r_count)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_count_next   = ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_head_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_count_next = FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_out_fire) begin
                        w_count_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_count_next     = ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: w_count_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= EMPTY;
        end else begin
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_imm <= '0;
            r_head_fmt <= '0;
            r_head_ill <= 1'b0;
            r_head_pc  <= '0;
            r_skid_imm <= '0;
            r_skid_fmt <= '0;
            r_skid_ill <= 1'b0;
            r_skid_pc  <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head_imm <= w_imm;
                r_head_fmt <= w_fmt;
                r_head_ill <= w_illegal;
                r_head_pc  <= in_pc;
            end else if (w_load_head_skid) begin
                r_head_imm <= r_skid_imm;
                r_head_fmt <= r_skid_fmt;
                r_head_ill <= r_skid_ill;
                r_head_pc  <= r_skid_pc;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_imm;
                r_skid_fmt <= w_fmt;
                r_skid_ill <= w_illegal;
                r_skid_pc  <= in_pc;
            end
        end
    end

    assign out_imm     = r_head_imm;
    assign out_fmt     = r_head_fmt;
    assign out_illegal = r_head_ill;
    assign out_pc      = r_head_pc;
    assign out_target  = r_head_pc + r_head_imm;

endmodule
